// File: rtl/uart_status_pkg.sv
// Shared encodings for the status-message UART: message types, ASCII characters,
// frame lengths and the byte-serialiser state type.
package uart_status_pkg;

    localparam logic [2:0] MSG_FIM = 3'd0;
    localparam logic [2:0] MSG_BPM = 3'd1;
    localparam logic [2:0] MSG_BDM = 3'd2;
    localparam logic [2:0] MSG_END = 3'd3;

    localparam logic [7:0] CH_F    = 8'h46;
    localparam logic [7:0] CH_I    = 8'h49;
    localparam logic [7:0] CH_M    = 8'h4D;
    localparam logic [7:0] CH_B    = 8'h42;
    localparam logic [7:0] CH_P    = 8'h50;
    localparam logic [7:0] CH_D    = 8'h44;
    localparam logic [7:0] CH_E    = 8'h45;
    localparam logic [7:0] CH_N    = 8'h4E;
    localparam logic [7:0] CH_S    = 8'h53;
    localparam logic [7:0] CH_U    = 8'h55;
    localparam logic [7:0] CH_C    = 8'h43;
    localparam logic [7:0] CH_R    = 8'h52;
    localparam logic [7:0] CH_DASH = 8'h2D;
    localparam logic [7:0] CH_HASH = 8'h23;
    localparam logic [7:0] CH_0    = 8'h30;

    localparam int LEN_UNIT = 10;
    localparam int LEN_END  = 5;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_e;

    // END ignores the unit fields; the unit-carrying messages need class E/C/R and digit 1-4.
    function automatic logic req_legal(logic [2:0] t, logic [1:0] c, logic [2:0] n);
        if (t == MSG_END) return 1'b1;
        if (t > MSG_END) return 1'b0;
        return (c != 2'd3) && (n >= 3'd1) && (n <= 3'd4);
    endfunction

endpackage

// File: rtl/uart_status_tx_if.sv
// Request handshake between the control logic and the status transmitter.
interface uart_status_tx_if;
    logic       msg_valid;
    logic       msg_ready;
    logic [2:0] msg_type;
    logic [1:0] unit_class;
    logic [2:0] unit_num;

    modport master (output msg_valid, msg_type, unit_class, unit_num, input msg_ready);
    modport slave  (input msg_valid, msg_type, unit_class, unit_num, output msg_ready);
endinterface

// File: rtl/uart_byte_ser.sv
// Single-byte 8N1 serialiser. A start seen during the last stop-bit cycle chains
// straight into the next start bit, so multi-byte frames have no idle gap.
module uart_byte_ser
    import uart_status_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    ser_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        bit_end = (cnt_q == CNT_LAST);

        if (state_q != SER_IDLE) cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);

        case (state_q)
            SER_IDLE: begin
                if (start) begin
                    state_d = SER_START;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            SER_START: begin
                // Byte is captured here, once the parent's latched fields are stable.
                if (bit_end) begin
                    state_d = SER_DATA;
                    shreg_d = data;
                    bit_d   = 3'd0;
                    tx_d    = data[0];
                end
            end
            SER_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = SER_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shreg_q[bit_d];
                    end
                end
            end
            SER_STOP: begin
                if (bit_end) begin
                    state_d = start ? SER_START : SER_IDLE;
                    tx_d    = ~start;
                end
            end
            default: state_d = SER_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q <= SER_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
        end
    end

    assign tx   = tx_q;
    assign busy = (state_q != SER_IDLE);
    assign done = (state_q == SER_STOP) && bit_end;

endmodule

// File: rtl/uart_status_tx.sv
// Status-message transmitter: frame sequencing and character ROM in front of the
// byte serialiser.
module uart_status_tx
    import uart_status_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_LEN      = 10
) (
    input  logic                   clk_50M,
    input  logic                   reset,
    uart_status_tx_if.slave        msg_if,
    output logic                   tx,
    output logic                   busy,
    output logic                   msg_done,
    output logic                   msg_err
);

    localparam int IDX_W = $clog2(MAX_LEN);

    logic [2:0]       type_q, type_d;
    logic [1:0]       class_q, class_d;
    logic [2:0]       num_q, num_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept, legal, last_byte, ser_start, ser_busy, ser_done;
    logic [IDX_W-1:0] last_idx;
    logic [7:0]       char_cur, tag0, tag1, tag2, cls_char;

    always_comb begin
        type_d    = type_q;
        class_d   = class_q;
        num_d     = num_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        ser_start = 1'b0;

        last_idx  = (type_q == MSG_END) ? IDX_W'(LEN_END - 1) : IDX_W'(LEN_UNIT - 1);
        last_byte = (idx_q == last_idx);
        accept    = msg_if.msg_valid && msg_if.msg_ready;
        legal     = req_legal(msg_if.msg_type, msg_if.unit_class, msg_if.unit_num);

        if (accept) begin
            type_d  = msg_if.msg_type;
            class_d = msg_if.unit_class;
            num_d   = msg_if.unit_num;
            idx_d   = '0;
            if (legal) ser_start = 1'b1;
            else       err_d     = 1'b1;
        end

        // accept needs an idle serialiser, so this never overlaps with the branch above.
        if (ser_done) begin
            if (last_byte) begin
                done_d = 1'b1;
                idx_d  = '0;
            end else begin
                idx_d     = idx_q + IDX_W'(1);
                ser_start = 1'b1;
            end
        end
    end

    always_comb begin
        tag0 = CH_B;
        tag1 = CH_D;
        tag2 = CH_M;
        case (type_q)
            MSG_FIM: begin tag0 = CH_F; tag1 = CH_I; end
            MSG_BPM: begin tag0 = CH_B; tag1 = CH_P; end
            MSG_BDM: begin tag0 = CH_B; tag1 = CH_D; end
            default: begin tag0 = CH_E; tag1 = CH_N; tag2 = CH_D; end
        endcase

        case (class_q)
            2'd0:    cls_char = CH_E;
            2'd1:    cls_char = CH_C;
            default: cls_char = CH_R;
        endcase

        char_cur = CH_HASH;
        if (type_q == MSG_END) begin
            case (int'(idx_q))
                0:       char_cur = tag0;
                1:       char_cur = tag1;
                2:       char_cur = tag2;
                3:       char_cur = CH_DASH;
                default: char_cur = CH_HASH;
            endcase
        end else begin
            case (int'(idx_q))
                0:       char_cur = tag0;
                1:       char_cur = tag1;
                2:       char_cur = tag2;
                3:       char_cur = CH_DASH;
                4:       char_cur = cls_char;
                5:       char_cur = CH_S;
                6:       char_cur = CH_U;
                7:       char_cur = CH_0 + {5'd0, num_q};
                8:       char_cur = CH_DASH;
                default: char_cur = CH_HASH;
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            type_q  <= '0;
            class_q <= '0;
            num_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            type_q  <= type_d;
            class_q <= class_d;
            num_q   <= num_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    uart_byte_ser #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
        .clk_50M (clk_50M),
        .reset   (reset),
        .start   (ser_start),
        .data    (char_cur),
        .tx      (tx),
        .busy    (ser_busy),
        .done    (ser_done)
    );

    assign msg_if.msg_ready = ~ser_busy;
    assign busy             = ser_busy;
    assign msg_done         = done_q;
    assign msg_err          = err_q;

endmodule
